// File: rtl/encoder_pkg.sv
// Types shared by the instruction encoder top level and its field packer.
package encoder_pkg;

    typedef enum logic [3:0] {
        FMT_R     = 4'd0,
        FMT_I     = 4'd1,
        FMT_LOAD  = 4'd2,
        FMT_S     = 4'd3,
        FMT_B     = 4'd4,
        FMT_LUI   = 4'd5,
        FMT_AUIPC = 4'd6,
        FMT_JAL   = 4'd7,
        FMT_JALR  = 4'd8
    } enc_fmt_t;

    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_BAD_FUNCT3 = 3'd1,
        ERR_RANGE      = 3'd2,
        ERR_MISALIGN   = 3'd3,
        ERR_UPPER      = 3'd4
    } enc_err_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } enc_state_t;

endpackage

// File: rtl/pkg.sv
// Shared RV32I base opcode constants used by the decode path and by
// anything that produces instruction words.
package pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

endpackage

// File: rtl/insn_field_pack.sv
// Combinational RV32I field packing with legality check.
// The error code reports the first failing check class in priority order.
module insn_field_pack
    import pkg::*;
    import encoder_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  enc_fmt_t          fmt_i,
    input  logic [2:0]        funct3_i,
    input  logic              alt_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [DWIDTH-1:0] imm_i,
    output logic [31:0]       insn_o,
    output enc_err_t          err_o
);

    logic signed [DWIDTH-1:0] simm;
    logic [31:0] imm;
    logic [6:0]  f7;
    logic        is_shift;
    logic        s12_bad;
    logic        f3_bad;
    logic        range_bad;
    logic        mis_bad;
    logic        upper_bad;

    assign simm     = imm_i;
    assign imm      = imm_i[31:0];
    assign f7       = alt_i ? 7'h20 : 7'h00;
    assign is_shift = (funct3_i == 3'd1) || (funct3_i == 3'd5);
    assign s12_bad  = (simm < -2048) || (simm > 2047);

    always_comb begin
        insn_o    = '0;
        f3_bad    = 1'b0;
        range_bad = 1'b0;
        mis_bad   = 1'b0;
        upper_bad = 1'b0;
        case (fmt_i)
            FMT_R: begin
                insn_o    = {f7, rs2_i, rs1_i, funct3_i, rd_i, OPC_OP};
                range_bad = alt_i && (funct3_i != 3'd0) && (funct3_i != 3'd5);
            end
            FMT_I: begin
                if (is_shift) begin
                    insn_o    = {f7, imm[4:0], rs1_i, funct3_i, rd_i, OPC_OP_IMM};
                    range_bad = (simm < 0) || (simm > 31);
                end else begin
                    insn_o    = {imm[11:0], rs1_i, funct3_i, rd_i, OPC_OP_IMM};
                    range_bad = s12_bad;
                end
            end
            FMT_LOAD: begin
                insn_o    = {imm[11:0], rs1_i, funct3_i, rd_i, OPC_LOAD};
                f3_bad    = (funct3_i == 3'd3) || (funct3_i >= 3'd6);
                range_bad = s12_bad;
            end
            FMT_S: begin
                insn_o    = {imm[11:5], rs2_i, rs1_i, funct3_i, imm[4:0], OPC_STORE};
                f3_bad    = funct3_i > 3'd2;
                range_bad = s12_bad;
            end
            FMT_B: begin
                insn_o    = {imm[12], imm[10:5], rs2_i, rs1_i, funct3_i,
                             imm[4:1], imm[11], OPC_BRANCH};
                f3_bad    = (funct3_i == 3'd2) || (funct3_i == 3'd3);
                range_bad = (simm < -4096) || (simm > 4094);
                mis_bad   = imm[0];
            end
            FMT_LUI: begin
                insn_o    = {imm[31:12], rd_i, OPC_LUI};
                upper_bad = imm[11:0] != 12'd0;
            end
            FMT_AUIPC: begin
                insn_o    = {imm[31:12], rd_i, OPC_AUIPC};
                upper_bad = imm[11:0] != 12'd0;
            end
            FMT_JAL: begin
                insn_o    = {imm[20], imm[10:1], imm[11], imm[19:12], rd_i, OPC_JAL};
                range_bad = (simm < -1048576) || (simm > 1048574);
                mis_bad   = imm[0];
            end
            FMT_JALR: begin
                insn_o    = {imm[11:0], rs1_i, 3'b000, rd_i, OPC_JALR};
                range_bad = s12_bad;
            end
            default: ;
        endcase
    end

    always_comb begin
        err_o = ERR_NONE;
        if (f3_bad)         err_o = ERR_BAD_FUNCT3;
        else if (range_bad) err_o = ERR_RANGE;
        else if (mis_bad)   err_o = ERR_MISALIGN;
        else if (upper_bad) err_o = ERR_UPPER;
    end

endmodule

// File: rtl/insn_encoder.sv
// Streaming RV32I encoder: request handshake in, addressed words out,
// halting on the first illegal request until the next start pulse.
module insn_encoder
    import encoder_pkg::*;
#(
    parameter int                DWIDTH    = 32,
    parameter int                AWIDTH    = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h0100_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [3:0]        req_fmt_i,
    input  logic [2:0]        req_funct3_i,
    input  logic              req_alt_i,
    input  logic [4:0]        req_rd_i,
    input  logic [4:0]        req_rs1_i,
    input  logic [4:0]        req_rs2_i,
    input  logic [DWIDTH-1:0] req_imm_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DWIDTH-1:0] out_insn_o,
    output logic [AWIDTH-1:0] out_addr_o,
    output logic [15:0]       count_o,
    output logic              err_o,
    output logic [2:0]        err_code_o
);

    enc_state_t        state_q, state_d;
    logic              valid_q, valid_d;
    logic [DWIDTH-1:0] insn_q, insn_d;
    logic [AWIDTH-1:0] oaddr_q, oaddr_d;
    logic [AWIDTH-1:0] naddr_q, naddr_d;
    logic [15:0]       count_q, count_d;
    logic              err_q, err_d;
    enc_err_t          code_q, code_d;
    logic [31:0]       pk_insn;
    enc_err_t          pk_err;
    logic              accept;
    logic              out_hs;

    insn_field_pack #(.DWIDTH(DWIDTH)) u_pack (
        .fmt_i    (enc_fmt_t'(req_fmt_i)),
        .funct3_i (req_funct3_i),
        .alt_i    (req_alt_i),
        .rd_i     (req_rd_i),
        .rs1_i    (req_rs1_i),
        .rs2_i    (req_rs2_i),
        .imm_i    (req_imm_i),
        .insn_o   (pk_insn),
        .err_o    (pk_err)
    );

    assign req_ready_o = (state_q == ST_RUN) & (!valid_q | out_ready_i) & !start_i;
    assign accept      = req_valid_i & req_ready_o;
    assign out_hs      = valid_q & out_ready_i;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        insn_d  = insn_q;
        oaddr_d = oaddr_q;
        naddr_d = naddr_q;
        count_d = count_q;
        err_d   = err_q;
        code_d  = code_q;
        if (start_i) begin
            state_d = ST_RUN;
            valid_d = 1'b0;
            naddr_d = BASE_ADDR;
            count_d = '0;
            err_d   = 1'b0;
            code_d  = ERR_NONE;
        end else begin
            if (out_hs) begin
                valid_d = 1'b0;
                count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
            end
            if (accept) begin
                if (pk_err == ERR_NONE) begin
                    valid_d = 1'b1;
                    insn_d  = DWIDTH'(pk_insn);
                    oaddr_d = naddr_q;
                    naddr_d = naddr_q + AWIDTH'(4);
                end else begin
                    err_d   = 1'b1;
                    code_d  = pk_err;
                    state_d = ST_HALT;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            insn_q  <= '0;
            oaddr_q <= BASE_ADDR;
            naddr_q <= BASE_ADDR;
            count_q <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            insn_q  <= insn_d;
            oaddr_q <= oaddr_d;
            naddr_q <= naddr_d;
            count_q <= count_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_insn_o  = insn_q;
    assign out_addr_o  = oaddr_q;
    assign count_o     = count_q;
    assign err_o       = err_q;
    assign err_code_o  = code_q;

endmodule

// File: tb/tb_insn_encoder.sv
// Directed self-checking bench for insn_encoder, including a second
// instance whose base address sits just below the address wrap point.
module tb_insn_encoder;
    import encoder_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_fmt;
    logic [2:0]  req_f3;
    logic        req_alt;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [31:0] req_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_insn;
    logic [31:0] out_addr;
    logic [15:0] count;
    logic        err;
    logic [2:0]  err_code;

    logic        b_start;
    logic        b_valid;
    logic        b_ready;
    logic [31:0] b_imm;
    logic        b_out_valid;
    logic [31:0] b_insn;
    logic [31:0] b_addr;
    logic [15:0] b_count;
    logic        b_err;
    logic [2:0]  b_code;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] b_exp [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

    always #5 clk = ~clk;

    insn_encoder dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_fmt_i    (req_fmt),
        .req_funct3_i (req_f3),
        .req_alt_i    (req_alt),
        .req_rd_i     (req_rd),
        .req_rs1_i    (req_rs1),
        .req_rs2_i    (req_rs2),
        .req_imm_i    (req_imm),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_insn_o   (out_insn),
        .out_addr_o   (out_addr),
        .count_o      (count),
        .err_o        (err),
        .err_code_o   (err_code)
    );

    insn_encoder #(.BASE_ADDR(32'hFFFF_FFF8)) dut_wrap (
        .clk          (clk),
        .reset        (reset),
        .start_i      (b_start),
        .req_valid_i  (b_valid),
        .req_ready_o  (b_ready),
        .req_fmt_i    (FMT_I),
        .req_funct3_i (3'd0),
        .req_alt_i    (1'b0),
        .req_rd_i     (5'd1),
        .req_rs1_i    (5'd0),
        .req_rs2_i    (5'd0),
        .req_imm_i    (b_imm),
        .out_valid_o  (b_out_valid),
        .out_ready_i  (1'b1),
        .out_insn_o   (b_insn),
        .out_addr_o   (b_addr),
        .count_o      (b_count),
        .err_o        (b_err),
        .err_code_o   (b_code)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] f, input logic [2:0] f3, input logic alt,
                         input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
        req_valid = 1'b1;
        req_fmt   = f;
        req_f3    = f3;
        req_alt   = alt;
        req_rd    = rd;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_imm   = imm;
    endtask

    task automatic pulse_start();
        req_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic bad(input string tag, input logic [3:0] f, input logic [2:0] f3,
                       input logic alt, input logic [31:0] imm, input logic [2:0] code);
        pulse_start();
        drive(f, f3, alt, 5'd1, 5'd1, 5'd2, imm);
        step();
        req_valid = 1'b0;
        chk({tag, "_err"}, {31'd0, err}, 32'd1);
        chk({tag, "_code"}, {29'd0, err_code}, {29'd0, code});
        chk({tag, "_novalid"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; req_valid = 1'b0; out_ready = 1'b1;
        req_fmt = '0; req_f3 = '0; req_alt = 1'b0;
        req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
        b_start = 1'b0; b_valid = 1'b0; b_imm = '0;
        step(); step();
        reset = 1'b0;
        step();

        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_insn", out_insn, 32'd0);
        chk("rst_addr", out_addr, 32'h0100_0000);
        chk("rst_count", {16'd0, count}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_code", {29'd0, err_code}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);

        start = 1'b1;
        #1;
        chk("start_blocks_ready", {31'd0, req_ready}, 32'd0);
        step();
        start = 1'b0;
        #1;
        chk("run_ready", {31'd0, req_ready}, 32'd1);

        drive(FMT_I, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        step();
        req_valid = 1'b0;
        chk("addi_valid", {31'd0, out_valid}, 32'd1);
        chk("addi_insn", out_insn, 32'h0050_0093);
        chk("addi_addr", out_addr, 32'h0100_0000);
        step();
        chk("addi_count", {16'd0, count}, 32'd1);
        chk("addi_drop", {31'd0, out_valid}, 32'd0);

        pulse_start();
        drive(FMT_R, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
        step();
        chk("sub_insn", out_insn, 32'h4020_81B3);
        chk("sub_addr", out_addr, 32'h0100_0000);
        drive(FMT_LUI, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        step();
        req_valid = 1'b0;
        chk("lui_insn", out_insn, 32'h1234_52B7);
        chk("lui_addr", out_addr, 32'h0100_0004);
        step();
        chk("lui_count", {16'd0, count}, 32'd2);

        drive(FMT_B, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd4);
        step();
        chk("beq_insn", out_insn, 32'hFE20_8EE3);
        chk("beq_addr", out_addr, 32'h0100_0008);
        req_imm = 32'd3;
        #1;
        chk("mis_ready", {31'd0, req_ready}, 32'd1);
        step();
        chk("mis_err", {31'd0, err}, 32'd1);
        chk("mis_code", {29'd0, err_code}, {29'd0, ERR_MISALIGN});
        chk("mis_noword", {31'd0, out_valid}, 32'd0);
        chk("mis_drain_count", {16'd0, count}, 32'd3);
        chk("halt_ready", {31'd0, req_ready}, 32'd0);
        step();
        chk("halt_hold_ready", {31'd0, req_ready}, 32'd0);
        chk("halt_hold_addr", out_addr, 32'h0100_0008);
        chk("halt_hold_count", {16'd0, count}, 32'd3);

        bad("f3_first", FMT_B, 3'd2, 1'b0, 32'd3, ERR_BAD_FUNCT3);
        bad("load_f3", FMT_LOAD, 3'd3, 1'b0, 32'd0, ERR_BAD_FUNCT3);
        bad("store_f3", FMT_S, 3'd3, 1'b0, 32'd0, ERR_BAD_FUNCT3);
        bad("i_range", FMT_I, 3'd0, 1'b0, 32'd2048, ERR_RANGE);
        bad("shamt_range", FMT_I, 3'd1, 1'b0, 32'd32, ERR_RANGE);
        bad("r_alt", FMT_R, 3'd1, 1'b1, 32'd0, ERR_RANGE);
        bad("b_range", FMT_B, 3'd0, 1'b0, 32'd4095, ERR_RANGE);
        bad("jal_mis", FMT_JAL, 3'd0, 1'b0, 32'd2049, ERR_MISALIGN);
        bad("lui_upper", FMT_LUI, 3'd0, 1'b0, 32'h1234_5001, ERR_UPPER);

        pulse_start();
        drive(FMT_JAL, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
        step();
        chk("jal_insn", out_insn, 32'h0080_00EF);
        drive(FMT_S, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
        step();
        chk("sw_insn", out_insn, 32'h0020_A423);
        drive(FMT_I, 3'd5, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3);
        step();
        chk("srai_insn", out_insn, 32'h4030_D093);
        drive(FMT_JALR, 3'd3, 1'b0, 5'd0, 5'd1, 5'd0, 32'd0);
        step();
        chk("jalr_insn", out_insn, 32'h0000_8067);
        chk("jalr_addr", out_addr, 32'h0100_000C);
        req_valid = 1'b0;
        step();

        pulse_start();
        drive(FMT_I, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1);
        step();
        out_ready = 1'b0;
        drive(FMT_I, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ready", {31'd0, req_ready}, 32'd0);
            chk("stall_insn", out_insn, 32'h0010_0093);
            chk("stall_addr", out_addr, 32'h0100_0000);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("s2_insn", out_insn, 32'h0020_0093);
        chk("s2_addr", out_addr, 32'h0100_0004);
        drive(FMT_I, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd3);
        step();
        chk("s3_insn", out_insn, 32'h0030_0093);
        chk("s3_addr", out_addr, 32'h0100_0008);
        drive(FMT_I, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4);
        step();
        chk("s4_insn", out_insn, 32'h0040_0093);
        chk("s4_addr", out_addr, 32'h0100_000C);
        req_valid = 1'b0;
        step();
        chk("stream_count", {16'd0, count}, 32'd4);
        chk("stream_drop", {31'd0, out_valid}, 32'd0);

        pulse_start();
        out_ready = 1'b0;
        drive(FMT_I, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        step();
        chk("pend_valid", {31'd0, out_valid}, 32'd1);
        start = 1'b1;
        req_imm = 32'd6;
        #1;
        chk("restart_ready", {31'd0, req_ready}, 32'd0);
        step();
        start = 1'b0;
        chk("restart_discard", {31'd0, out_valid}, 32'd0);
        chk("restart_count", {16'd0, count}, 32'd0);
        out_ready = 1'b1;
        step();
        req_valid = 1'b0;
        chk("restart_insn", out_insn, 32'h0060_0093);
        chk("restart_addr", out_addr, 32'h0100_0000);

        out_ready = 1'b0;
        drive(FMT_I, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd7);
        step();
        reset = 1'b1;
        step();
        chk("mrst_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_insn", out_insn, 32'd0);
        chk("mrst_addr", out_addr, 32'h0100_0000);
        chk("mrst_count", {16'd0, count}, 32'd0);
        chk("mrst_ready", {31'd0, req_ready}, 32'd0);
        reset = 1'b0;
        req_valid = 1'b0;
        out_ready = 1'b1;
        step();

        b_start = 1'b1;
        step();
        b_start = 1'b0;
        b_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            b_imm = 32'(k + 1);
            step();
            chk("wrap_addr", b_addr, b_exp[k]);
        end
        b_valid = 1'b0;
        step();
        chk("wrap_count", {16'd0, b_count}, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/insn_encoder.md
# insn_encoder

Streaming RV32I instruction encoder: accepts decoded instruction fields (format, funct3, alt bit, rd/rs1/rs2, full-width immediate) over a valid/ready handshake, and emits legal 32-bit instruction words tagged with sequential addresses. It is the inverse of the decode/control path. It feeds instruction-memory preload and the self-checking program generator in the PD benches. It checks field legality and halts on the first illegal request.

## Interface
- `DWIDTH`, 32, instruction/immediate width
- `AWIDTH`, 32, address width
- `BASE_ADDR`, 32'h0100_0000, address of first emitted word after `start_i`
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start_i`  in  1  pulse: address := `BASE_ADDR`, count := 0, error cleared, state := RUN
- `req_valid_i`  in  1  request valid
- `req_ready_o`  out  1  request accepted when valid & ready
- `req_fmt_i`  in  4  `enc_fmt_t`: R, I, LOAD, S, B, LUI, AUIPC, JAL, JALR
- `req_funct3_i`  in  3  funct3
- `req_alt_i`  in  1  funct7[5] for R-type and for SRAI
- `req_rd_i`, `req_rs1_i`, `req_rs2_i`  in  5 each  register indices
- `req_imm_i`  in  DWIDTH  signed byte-offset/immediate (LUI/AUIPC: full value, low 12 bits must be 0)
- `out_valid_o`  out  1  encoded word valid
- `out_ready_i`  in  1  consumer accepts word
- `out_insn_o`  out  DWIDTH  encoded instruction
- `out_addr_o`  out  AWIDTH  address of `out_insn_o`
- `count_o`  out  16  words emitted since `start_i` (saturates at 16'hFFFF)
- `err_o`  out  1  sticky error
- `err_code_o`  out  3  `enc_err_t` of first error

## Operation
- States: IDLE (after reset), RUN, HALT.
- IDLE → RUN on `start_i`.
- RUN → HALT on acceptance of an illegal request.
- HALT → RUN on `start_i`.
- `start_i` in any state restarts. `start_i` has priority over a same-cycle request: that request is not accepted.
- `req_ready_o` = (state==RUN) & (!out_valid_o | out_ready_i) & !`start_i`.
- Encoding uses the RV32I base opcodes from the shared constants.
- R-type: funct7 = alt ? 7'h20 : 0.
- I-type shifts (funct3 1/5): imm[4:0] in shamt field, funct7 = alt ? 7'h20 : 0.
- JALR: funct3 forced to 0.
- Unused fields are zero.
- Legality checks; the first failing check in this order sets the code:
  - BAD_FUNCT3: LOAD f3 ∉ {0,1,2,4,5}; S f3 ∉ {0,1,2}; B f3 ∈ {2,3}.
  - RANGE:
    - I/LOAD/S/JALR imm outside [-2048, 2047].
    - B imm outside [-4096, 4094].
    - JAL imm outside [-2^20, 2^20-2].
    - Shift imm outside [0, 31].
    - R with alt=1 and f3 ∉ {0,5}.
  - MISALIGN: B/JAL imm[0]≠0.
  - UPPER: LUI/AUIPC imm[11:0]≠0.
- An illegal request is consumed: handshake completes, no word is emitted.
  - Sets `err_o` and `err_code_o`; address/count unchanged; state → HALT.
  - A word already in the output register still drains.
- Address increments by 4 per legal accepted request, wrapping modulo 2^AWIDTH.
- Reset values: state IDLE, `out_valid_o`=0, `out_insn_o`=0, `out_addr_o`=`BASE_ADDR`, `count_o`=0, `err_o`=0, `err_code_o`=NONE(0), `req_ready_o`=0.

## Timing
- Latency 1: request accepted at edge N → `out_valid_o` high after edge N, holding word and address.
- Full throughput: with `out_ready_i` held high, one word per cycle.
- Backpressure: `out_valid_o`, `out_insn_o`, `out_addr_o` stable while `out_valid_o & !out_ready_i`.
- `out_valid_o` drops the cycle after the output handshake if no new request is accepted.
- `count_o` increments on the output handshake, not on acceptance.
- `start_i` clears `out_valid_o` at the same edge and discards any pending word.
- `reset` mid-stream returns all outputs to reset values at the next edge regardless of other inputs.

## Structure
- Package `encoder_pkg`: `enc_fmt_t` (4-bit), `enc_err_t` (NONE, BAD_FUNCT3, RANGE, MISALIGN, UPPER), state enum.
- Opcodes are reused from the existing shared constants; do not redefine them.
- Sub-module `insn_field_pack`: purely combinational field packing plus legality check; outputs word + `enc_err_t`.
- Top level holds FSM, output register, address and count counters.

## Test plan
- Reset then `start_i`; ADDI fmt=I, rd=1, rs1=0, imm=5 → 0x00500093 at 0x0100_0000, `count_o`=1.
- R fmt, alt=1, f3=0, rd=3, rs1=1, rs2=2 → 0x402081B3; then LUI rd=5, imm=0x12345000 → 0x123452B7 at 0x0100_0004.
- B fmt, f3=0, rs1=1, rs2=2, imm=-4 → 0xFE208EE3; same request with imm=3 → `err_o`=1, code MISALIGN, no word, `req_ready_o`=0 until `start_i`.
- Back-to-back stream of 4 requests with `out_ready_i`=0 for 3 cycles mid-stream → words held stable, addresses contiguous, no loss or duplication, `count_o`=4.
- `start_i` asserted with a word pending and a request valid → word discarded, request not accepted, next word addressed 0x0100_0000.
- `BASE_ADDR`=32'hFFFF_FFF8, 3 legal requests → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
